stim_gen: RTL and testbench
===========================

STIM_GEN -- requirements
Module: stim_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 16, stream data width (8/16/32).
REQ-002 SHALL have parameter CNT_W, default 32, free-running cycle counter width.
REQ-003 SHALL have parameter DIV_STAGES, default 3, number of divide-by-2 stages.
REQ-004 SHALL have parameter IDLE_LEN, default 256, WAIT phase length in cycles (>=1).
REQ-005 SHALL have parameter STREAM_LEN, default 65536, accepted beats per STREAM phase (>=1).
REQ-006 SHALL have parameter FLAG_W, default 4, flag counter width.
REQ-007 SHALL have port sys_clk_i, input, 1, the single clock.
REQ-008 SHALL have port sys_rst_i, input, 1, reset; asynchronous, active-high.
REQ-009 SHALL have port en_i, input, 1, run request.
REQ-010 SHALL have port ready_i, input, 1, sink ready.
REQ-011 SHALL have port valid_o, output, 1, data valid.
REQ-012 SHALL have port data_o, output, DATA_W, stream data.
REQ-013 SHALL have port clk_div_o, output, DIV_STAGES, divided clock bits; bit k has period 2^(k+1) cycles.
REQ-014 SHALL have port cnt_o, output, CNT_W, cycle counter.
REQ-015 SHALL have port state_o, output, 2, current state code.
REQ-016 SHALL have port flags_o, output, FLAG_W, flag counter.
REQ-017 SHALL have port status_o, output, 8, status shift register.
REQ-018 SHALL have port round_o, output, 16, completed-round count.
REQ-019 SHALL have port done_o, output, 1, one-cycle pulse at round end.

Function
REQ-020 cnt_o SHALL increment by 1 every cycle, wrapping modulo 2^CNT_W, independent of en_i.
REQ-021 clk_div_o[0] SHALL toggle every cycle; bit k SHALL toggle when bits 0..k-1 are all 1; free-running.
REQ-022 States SHALL be IDLE=0, WAIT=1, STREAM=2, FLAGS=3.
REQ-023 IDLE: en_i=1 -> WAIT next cycle; phase counter cleared.
REQ-024 WAIT: phase counter increments; at IDLE_LEN-1 -> STREAM; en_i=0 -> IDLE immediately.
REQ-025 STREAM: valid_o=1; beat accepted when valid_o&&ready_i; on accept data_o increments by 1 (mod 2^DATA_W), beat counter increments.
REQ-026 STREAM: data_o and valid_o SHALL hold stable while ready_i=0.
REQ-027 STREAM_LEN-th accept -> FLAGS next cycle; valid_o=0 from that cycle.
REQ-028 en_i=0 in STREAM: valid_o stays 1 until current beat accepted, then -> IDLE.
REQ-029 FLAGS: flags_o increments each cycle; status_o <= {status_o[6:0], cnt_o[0]} each cycle.
REQ-030 FLAGS with flags_o all-ones: done_o=1 for that cycle, round_o increments (wraps at 16 bits), flags_o wraps to 0, -> WAIT if en_i=1 else IDLE.
REQ-031 data_o SHALL persist across rounds (not cleared on re-entry to STREAM).
REQ-032 valid_o SHALL be 0 in IDLE, WAIT, FLAGS.

Reset
REQ-033 sys_rst_i=1 SHALL immediately force all outputs and counters to 0, state IDLE, at any point including mid-beat.
REQ-034 First state change SHALL occur no earlier than first sys_clk_i rising edge after sys_rst_i falls.

Configuration
REQ-035 STIM_GEN_LFSR_EN defined: data_o SHALL be a Fibonacci LFSR, reset seed all-ones-xor-0x5A5A (truncated to DATA_W), advanced only on accept.
REQ-036 STIM_GEN_LFSR_EN undefined: data_o SHALL be the incrementing counter of REQ-025; no LFSR logic.

Structure
REQ-037 Package stim_gen_pkg SHALL hold state enum, state codes, LFSR tap constants for 8/16/32 and LFSR seed.
REQ-038 Divider SHALL be sub-module stim_gen_clkdiv (parameter DIV_STAGES).

Verification
REQ-039 IDLE_LEN=4, STREAM_LEN=8, ready_i=1, en_i=1 -> valid_o high cycles 5..12 after en, data_o 0..7, done_o pulse 16 cycles after FLAGS entry, round_o=1.
REQ-040 ready_i toggling 1,0,1,0 in STREAM -> data_o held during ready_i=0, exactly 8 accepts, final data_o=8.
REQ-041 en_i dropped with valid_o=1, ready_i=0 for 3 cycles -> valid_o held, then IDLE on first accept.
REQ-042 sys_rst_i pulsed mid-STREAM -> all outputs 0, state_o=0 same cycle, clk_div_o restarts from 0.
REQ-043 Free run 16 cycles after reset, DIV_STAGES=3 -> clk_div_o periods 2/4/8, cnt_o=16.
REQ-044 STIM_GEN_LFSR_EN, DATA_W=16 -> 8 accepted values match reference LFSR model, no repeats.

Source files
------------

// File: rtl/stim_gen_pkg.sv
// stim_gen_pkg: shared types and constants for the stimulus generator.
// Holds the state encoding, Fibonacci LFSR tap masks for 8/16/32-bit data,
// the LFSR reset seed and a width-generic LFSR step helper.
package stim_gen_pkg;

   // State codes are visible on state_o, so the encoding is fixed.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_STREAM = 2'd2,
      S_FLAGS  = 2'd3
   } state_e;

   // Fibonacci tap masks (bit i set = stage i+1 feeds the XOR).
   // 8:  x^8  + x^6  + x^5 + x^4 + 1
   // 16: x^16 + x^14 + x^13 + x^11 + 1
   // 32: x^32 + x^22 + x^2 + x^1 + 1
   localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
   localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
   localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

   // Seed is all-ones xor 0x5A5A; users truncate it to the data width.
   localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF ^ 32'h0000_5A5A;

   // Select the tap mask that matches a supported data width.
   function automatic logic [31:0] lfsr_taps(input int unsigned width);
      logic [31:0] taps;
      case (width)
         32'd8:   taps = LFSR_TAPS_8;
         32'd16:  taps = LFSR_TAPS_16;
         32'd32:  taps = LFSR_TAPS_32;
         default: taps = LFSR_TAPS_16;
      endcase
      return taps;
   endfunction

   // One left-shifting Fibonacci step; the XOR of tapped bits enters at bit 0.
   function automatic logic [31:0] lfsr_step(input logic [31:0] value,
                                              input logic [31:0] taps,
                                              input int unsigned width);
      logic        fb;
      logic [31:0] mask;
      fb   = ^(value & taps);
      mask = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return ((value << 1) | {31'd0, fb}) & mask;
   endfunction

endpackage

// File: rtl/stim_gen_clkdiv.sv
// stim_gen_clkdiv: free-running ripple-style divider built as a synchronous
// binary counter. Bit 0 toggles every cycle and bit k toggles when bits
// 0..k-1 are all ones, so bit k has a period of 2^(k+1) cycles.
module stim_gen_clkdiv #(
   parameter int DIV_STAGES = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic [DIV_STAGES-1:0] div_o
);

   logic [DIV_STAGES-1:0] div_q;
   logic [DIV_STAGES-1:0] div_d;
   logic                  carry_s;

   // Toggle each stage when every lower stage is high.
   always_comb begin
      div_d   = div_q;
      carry_s = 1'b1;
      for (int k = 0; k < DIV_STAGES; k++) begin
         div_d[k] = div_q[k] ^ carry_s;
         carry_s  = carry_s & div_q[k];
      end
   end

   // Divider register, cleared asynchronously so it restarts from zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q <= {DIV_STAGES{1'b0}};
      end else begin
         div_q <= div_d;
      end
   end

   assign div_o = div_q;

endmodule

// File: rtl/stim_gen.sv
// stim_gen: stimulus generator. Runs IDLE -> WAIT -> STREAM -> FLAGS rounds,
// emitting STREAM_LEN valid/ready beats per round, plus a free-running cycle
// counter and clock divider.
// Build option: define STIM_GEN_LFSR_EN to make data_o a Fibonacci LFSR
// (advanced on each accepted beat) instead of an incrementing counter.
import stim_gen_pkg::*;

module stim_gen #(
   parameter int DATA_W     = 16,
   parameter int CNT_W      = 32,
   parameter int DIV_STAGES = 3,
   parameter int IDLE_LEN   = 256,
   parameter int STREAM_LEN = 65536,
   parameter int FLAG_W     = 4
) (
   input  logic                  sys_clk_i,
   input  logic                  sys_rst_i,
   input  logic                  en_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_W-1:0]     data_o,
   output logic [DIV_STAGES-1:0] clk_div_o,
   output logic [CNT_W-1:0]      cnt_o,
   output logic [1:0]            state_o,
   output logic [FLAG_W-1:0]     flags_o,
   output logic [7:0]            status_o,
   output logic [15:0]           round_o,
   output logic                  done_o
);

   localparam int PH_W = (IDLE_LEN > 1) ? $clog2(IDLE_LEN) : 1;
   localparam int BT_W = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(IDLE_LEN - 1);
   localparam logic [BT_W-1:0] BT_LAST = BT_W'(STREAM_LEN - 1);
   localparam logic [FLAG_W-1:0] FLAGS_MAX = {FLAG_W{1'b1}};

   state_e              state_q,  state_d;
   logic [PH_W-1:0]     phase_q,  phase_d;
   logic [BT_W-1:0]     beat_q,   beat_d;
   logic [DATA_W-1:0]   data_q,   data_d;
   logic                valid_q,  valid_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [FLAG_W-1:0]   flags_q,  flags_d;
   logic [7:0]          status_q, status_d;
   logic [15:0]         round_q,  round_d;
   logic                done_q,   done_d;
   logic                accept_s;
   logic [DATA_W-1:0]   data_nxt_s;

`ifdef STIM_GEN_LFSR_EN
   localparam logic [31:0]       TAPS = lfsr_taps(DATA_W);
   localparam logic [DATA_W-1:0] DATA_RST = LFSR_SEED[DATA_W-1:0];
   logic [31:0] data_step_s;

   // Next LFSR value, used only when a beat is accepted.
   always_comb begin
      data_step_s = lfsr_step(32'(data_q), TAPS, DATA_W);
      data_nxt_s  = data_step_s[DATA_W-1:0];
   end
`else
   localparam logic [DATA_W-1:0] DATA_RST = {DATA_W{1'b0}};

   // Next counter value, used only when a beat is accepted.
   always_comb begin
      data_nxt_s = data_q + DATA_W'(1);
   end
`endif

   assign accept_s = valid_q & ready_i;

   // Next-state and datapath: phase/beat counters clear outside their own
   // states; outputs are registered from the next-state values.
   always_comb begin
      state_d  = state_q;
      phase_d  = {PH_W{1'b0}};
      beat_d   = {BT_W{1'b0}};
      data_d   = data_q;
      flags_d  = flags_q;
      status_d = status_q;
      round_d  = round_q;
      cnt_d    = cnt_q + CNT_W'(1);
      case (state_q)
         S_IDLE: begin
            if (en_i) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!en_i) begin
               state_d = S_IDLE;
            end else if (phase_q == PH_LAST) begin
               state_d = S_STREAM;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         S_STREAM: begin
            // A dropped en_i only takes effect once the pending beat is taken.
            if (accept_s) begin
               data_d = data_nxt_s;
               if (beat_q == BT_LAST) begin
                  state_d = S_FLAGS;
               end else if (!en_i) begin
                  state_d = S_IDLE;
               end else begin
                  beat_d = beat_q + BT_W'(1);
               end
            end else begin
               beat_d = beat_q;
            end
         end
         S_FLAGS: begin
            status_d = {status_q[6:0], cnt_q[0]};
            if (flags_q == FLAGS_MAX) begin
               flags_d = {FLAG_W{1'b0}};
               round_d = round_q + 16'd1;
               if (en_i) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               flags_d = flags_q + FLAG_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      valid_d = (state_d == S_STREAM);
      done_d  = (state_d == S_FLAGS) && (flags_d == FLAGS_MAX);
   end

   // State and output registers, asynchronously cleared.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q  <= S_IDLE;
         phase_q  <= {PH_W{1'b0}};
         beat_q   <= {BT_W{1'b0}};
         data_q   <= DATA_RST;
         valid_q  <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         flags_q  <= {FLAG_W{1'b0}};
         status_q <= 8'd0;
         round_q  <= 16'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         beat_q   <= beat_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
         flags_q  <= flags_d;
         status_q <= status_d;
         round_q  <= round_d;
         done_q   <= done_d;
      end
   end

   stim_gen_clkdiv #(
      .DIV_STAGES (DIV_STAGES)
   ) u_clkdiv (
      .clk_i (sys_clk_i),
      .rst_i (sys_rst_i),
      .div_o (clk_div_o)
   );

   assign valid_o  = valid_q;
   assign data_o   = data_q;
   assign cnt_o    = cnt_q;
   assign state_o  = state_q;
   assign flags_o  = flags_q;
   assign status_o = status_q;
   assign round_o  = round_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_stim_gen.sv
// tb_stim_gen: table-driven bench for stim_gen with IDLE_LEN=4, STREAM_LEN=8.
// Each table record holds the inputs for one clock edge and the outputs
// expected just after it; reset-related sequences are written by hand.
module tb_stim_gen;

   logic        clk;
   logic        rst;
   logic        en_i;
   logic        ready_i;
   logic        valid_o;
   logic [15:0] data_o;
   logic [2:0]  clk_div_o;
   logic [31:0] cnt_o;
   logic [1:0]  state_o;
   logic [3:0]  flags_o;
   logic [7:0]  status_o;
   logic [15:0] round_o;
   logic        done_o;

   typedef struct {
      logic        en;
      logic        rdy;
      logic [1:0]  st;
      logic        vld;
      int          dix;
      logic [3:0]  flags;
      logic        done;
      logic [15:0] rnd;
   } vec_t;

   vec_t tab_a[$];
   vec_t tab_b[$];

   int          n_checks;
   int          n_fail;
   int          step_no;
   int          cnt_exp;
   logic [7:0]  status_exp;
   logic [1:0]  cur_st;

   stim_gen #(
      .DATA_W     (16),
      .CNT_W      (32),
      .DIV_STAGES (3),
      .IDLE_LEN   (4),
      .STREAM_LEN (8),
      .FLAG_W     (4)
   ) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .en_i      (en_i),
      .ready_i   (ready_i),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .clk_div_o (clk_div_o),
      .cnt_o     (cnt_o),
      .state_o   (state_o),
      .flags_o   (flags_o),
      .status_o  (status_o),
      .round_o   (round_o),
      .done_o    (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // n-th data value of the stream (counter, or reference LFSR model).
   function automatic logic [15:0] exp_data(input int n);
      logic [15:0] d;
`ifdef STIM_GEN_LFSR_EN
      d = 16'hA5A5;
      for (int i = 0; i < n; i++) begin
         d = {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
      end
`else
      d = 16'(n);
`endif
      return d;
   endfunction

   function automatic vec_t mk(input logic en, input logic rdy, input logic [1:0] st,
                               input logic vld, input int dix, input int flg,
                               input logic done, input int rnd);
      vec_t v;
      v.en = en; v.rdy = rdy; v.st = st; v.vld = vld; v.dix = dix;
      v.flags = 4'(flg); v.done = done; v.rnd = 16'(rnd);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", name, step_no, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      en_i    = v.en;
      ready_i = v.rdy;
      if (cur_st == 2'd3) status_exp = {status_exp[6:0], cnt_exp[0]};
      @(posedge clk);
      #1;
      cnt_exp++;
      step_no++;
      cur_st = v.st;
      chk("state",   32'(state_o),   32'(v.st));
      chk("valid",   32'(valid_o),   32'(v.vld));
      chk("data",    32'(data_o),    32'(exp_data(v.dix)));
      chk("flags",   32'(flags_o),   32'(v.flags));
      chk("done",    32'(done_o),    32'(v.done));
      chk("round",   32'(round_o),   32'(v.rnd));
      chk("cnt",     cnt_o,          32'(cnt_exp));
      chk("clk_div", 32'(clk_div_o), 32'(cnt_exp % 8));
      chk("status",  32'(status_o),  32'(status_exp));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"},   32'(state_o),   32'd0);
      chk({tag, "_valid"},   32'(valid_o),   32'd0);
      chk({tag, "_data"},    32'(data_o),    32'(exp_data(0)));
      chk({tag, "_clk_div"}, 32'(clk_div_o), 32'd0);
      chk({tag, "_cnt"},     cnt_o,          32'd0);
      chk({tag, "_flags"},   32'(flags_o),   32'd0);
      chk({tag, "_status"},  32'(status_o),  32'd0);
      chk({tag, "_round"},   32'(round_o),   32'd0);
      chk({tag, "_done"},    32'(done_o),    32'd0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0; step_no = 0;
      cnt_exp = 0; status_exp = 8'd0; cur_st = 2'd0;

      // Table A: 16 free-running idle cycles, then one full round and
      // the start of the next round (data persists across rounds).
      for (int i = 0; i < 16; i++) tab_a.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 1'b0, 0));
      for (int k = 1; k <= 4; k++)   tab_a.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 0, 0, 1'b0, 0));
      for (int k = 5; k <= 12; k++)  tab_a.push_back(mk(1'b1, 1'b1, 2'd2, 1'b1, k - 5, 0, 1'b0, 0));
      for (int k = 13; k <= 27; k++) tab_a.push_back(mk(1'b1, 1'b1, 2'd3, 1'b0, 8, k - 13, 1'b0, 0));
      tab_a.push_back(mk(1'b1, 1'b1, 2'd3, 1'b0, 8, 15, 1'b1, 0));
      for (int k = 29; k <= 32; k++) tab_a.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 8, 0, 1'b0, 1));
      tab_a.push_back(mk(1'b1, 1'b1, 2'd2, 1'b1, 8, 0, 1'b0, 1));
      tab_a.push_back(mk(1'b1, 1'b1, 2'd2, 1'b1, 9, 0, 1'b0, 1));

      // Table B: ready toggling during STREAM, then a round where en_i
      // drops while a beat is pending.
      for (int k = 1; k <= 4; k++)   tab_b.push_back(mk(1'b1, 1'(k % 2 == 0), 2'd1, 1'b0, 0, 0, 1'b0, 0));
      for (int k = 5; k <= 19; k++)  tab_b.push_back(mk(1'b1, 1'(k % 2 == 0), 2'd2, 1'b1, (k - 4) / 2, 0, 1'b0, 0));
      for (int k = 20; k <= 34; k++) tab_b.push_back(mk(1'b1, 1'b1, 2'd3, 1'b0, 8, k - 20, 1'b0, 0));
      tab_b.push_back(mk(1'b1, 1'b1, 2'd3, 1'b0, 8, 15, 1'b1, 0));
      for (int k = 36; k <= 39; k++) tab_b.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 8, 0, 1'b0, 1));
      tab_b.push_back(mk(1'b1, 1'b1, 2'd2, 1'b1, 8, 0, 1'b0, 1));
      for (int k = 41; k <= 43; k++) tab_b.push_back(mk(1'b0, 1'b0, 2'd2, 1'b1, 8, 0, 1'b0, 1));
      tab_b.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 9, 0, 1'b0, 1));
      tab_b.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 9, 0, 1'b0, 1));

      // Power-on reset held across one edge.
      rst = 1'b1; en_i = 1'b0; ready_i = 1'b0;
      @(posedge clk);
      #1;
      chk_reset("por");
      #3 rst = 1'b0;

      for (int i = 0; i < tab_a.size(); i++) apply(tab_a[i]);

      // Asynchronous reset in the middle of a STREAM beat.
      #3 rst = 1'b1;
      en_i = 1'b0; ready_i = 1'b0;
      #1;
      chk_reset("async_rst");
      @(posedge clk);
      #1;
      chk_reset("rst_held");
      #3 rst = 1'b0;
      cnt_exp = 0; status_exp = 8'd0; cur_st = 2'd0;

      for (int i = 0; i < tab_b.size(); i++) apply(tab_b[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
